// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the iterative ALU: opcode encodings (alucontrol field)
// and the controller state type. Imported by alu_iter.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_MUL  = 4'b1001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // True for the codes whose result is a single-bit shift sequence.
  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// -----------------------------------------------------------------------------
// alu_addsub
// WIDTH-bit parallel-prefix (Kogge-Stone) carry-lookahead adder/subtractor.
//   a, b  : operands
//   sub   : 1 -> a - b (two's complement, carry-in 1), 0 -> a + b
//   sum   : result modulo 2^WIDTH
//   cout  : carry out of the MSB (for subtraction: 1 means no borrow)
// -----------------------------------------------------------------------------
module alu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int STAGES = $clog2(WIDTH);

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] p0;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g_n;
  logic [WIDTH-1:0] p_n;

  // NOTE: every variable written here gets a value on every path before it is
  // read, so this stays pure combinational logic with no inferred latch.
  always_comb begin
    bx = b ^ {WIDTH{sub}};
    p0 = a ^ bx;
    g  = a & bx;
    p  = p0;
    // Fold the carry-in into bit 0's generate so the prefix tree needs no
    // extra column.
    g[0] = g[0] | (p0[0] & sub);
    g_n  = g;
    p_n  = p;
    for (int k = 0; k < STAGES; k++) begin
      g_n = g;
      p_n = p;
      for (int i = (1 << k); i < WIDTH; i++) begin
        g_n[i] = g[i] | (p[i] & g[i - (1 << k)]);
        p_n[i] = p[i] & p[i - (1 << k)];
      end
      g = g_n;
      p = p_n;
    end
    // After the tree, g[i] is the carry out of bit i.
    sum  = p0 ^ {g[WIDTH-2:0], sub};
    cout = g[WIDTH-1];
  end

endmodule

// File: rtl/alu_iter.sv
// -----------------------------------------------------------------------------
// alu_iter
// Iterative ALU with valid/ready handshakes on both sides. Simple ops finish in
// one cycle; shifts move one bit per cycle; the optional multiplier is a
// WIDTH-cycle shift-add loop sharing the add/sub unit.
//
// Configuration macro: ALU_ITER_MUL_EN
//   defined   -> opcode 1001 multiplies (low WIDTH bits of the product)
//   undefined -> no multiplier; 1001 behaves as an undefined code (result 0)
//
// Ports
//   clk        : clock, rising edge
//   reset_n    : synchronous active-low reset
//   in_valid   : request present          in_ready  : accepting (IDLE only)
//   srca, srcb : operands                 alucontrol: opcode
//   shamt      : shift amount
//   out_valid  : result available         out_ready : consumer takes result
//   aluout     : registered result        zero      : (srca == srcb) of request
//   busy       : controller not in IDLE
// -----------------------------------------------------------------------------
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [3:0]       alucontrol,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluout,
  output logic             zero,
  output logic             busy
);

  // One extra bit so the multiply loop can count WIDTH iterations.
  localparam int CNT_W = SHW + 1;

  state_t           state;
  logic [WIDTH-1:0] a_q;       // shift data / multiplicand
  logic [3:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] aluout_q;
  logic             zero_q;
  logic             out_valid_q;
`ifdef ALU_ITER_MUL_EN
  logic [WIDTH-1:0] b_q;       // multiplier, consumed LSB first
  logic [WIDTH-1:0] acc_q;     // partial product
  logic [WIDTH-1:0] mul_next;
`endif

  logic             accept;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_sub;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             ovf;
  logic             lt_s;
  logic             lt_u;
  logic [WIDTH-1:0] quick_res;
  logic [WIDTH-1:0] sh_next;
  logic             long_shift;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = out_valid_q;
  assign aluout    = aluout_q;
  assign zero      = zero_q;
  assign accept    = in_valid && in_ready;

  // The adder serves the live request in IDLE and the accumulator in MUL.
  always_comb begin
    add_a   = srca;
    add_b   = srcb;
    add_sub = (alucontrol != OP_ADD);
`ifdef ALU_ITER_MUL_EN
    if (state == MUL) begin
      add_a   = acc_q;
      add_b   = a_q;
      add_sub = 1'b0;
    end
`endif
  end

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (add_a),
    .b    (add_b),
    .sub  (add_sub),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Single-cycle results, valid while in IDLE with the request on the inputs.
  always_comb begin
    // Signed overflow of A-B: operand signs differ and the result sign
    // differs from A's.
    ovf  = (srca[WIDTH-1] ^ srcb[WIDTH-1]) & (add_sum[WIDTH-1] ^ srca[WIDTH-1]);
    lt_s = add_sum[WIDTH-1] ^ ovf;
    lt_u = ~add_cout;
    unique case (alucontrol)
      OP_ADD, OP_SUB:         quick_res = add_sum;
      OP_SLT:                 quick_res = WIDTH'(lt_s);
      OP_SLTU:                quick_res = WIDTH'(lt_u);
      OP_XOR:                 quick_res = srca ^ srcb;
      OP_OR:                  quick_res = srca | srcb;
      OP_AND:                 quick_res = srca & srcb;
      OP_SLL, OP_SRL, OP_SRA: quick_res = srca;   // only reached with shamt 0
      default:                quick_res = '0;
    endcase
  end

  assign long_shift = is_shift_op(alucontrol) && (shamt != '0);

  always_comb begin
    unique case (op_q)
      OP_SLL:  sh_next = a_q << 1;
      OP_SRA:  sh_next = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
      default: sh_next = a_q >> 1;
    endcase
  end

`ifdef ALU_ITER_MUL_EN
  assign mul_next = b_q[0] ? add_sum : acc_q;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: the working registers are reset along with the visible outputs;
    // there are only a few of them and it keeps an aborted operation from
    // leaving stale data behind.
    if (!reset_n) begin
      state       <= IDLE;
      a_q         <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      aluout_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ALU_ITER_MUL_EN
      b_q         <= '0;
      acc_q       <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_q    <= srca;
            op_q   <= alucontrol;
            zero_q <= (srca == srcb);
`ifdef ALU_ITER_MUL_EN
            b_q    <= srcb;
            acc_q  <= '0;
`endif
            if (long_shift) begin
              cnt_q <= CNT_W'(shamt);
              state <= SHIFT;
`ifdef ALU_ITER_MUL_EN
            end else if (alucontrol == OP_MUL) begin
              cnt_q <= CNT_W'(WIDTH);
              state <= MUL;
`endif
            end else begin
              aluout_q    <= quick_res;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end
          end
        end

        SHIFT: begin
          a_q   <= sh_next;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            aluout_q    <= sh_next;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end

`ifdef ALU_ITER_MUL_EN
        MUL: begin
          acc_q <= mul_next;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            aluout_q    <= mul_next;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
`endif

        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// -----------------------------------------------------------------------------
// tb_alu_iter
// Self-checking bench for alu_iter (WIDTH=32). A behavioural model gives the
// result and latency of each request; one compare process checks the DUT
// outputs every cycle against the pending expectation. Multiply expectations
// follow ALU_ITER_MUL_EN.
// -----------------------------------------------------------------------------
module tb_alu_iter;

  localparam int W = 32;

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  srca;
  logic [W-1:0]  srcb;
  logic [3:0]    alucontrol;
  logic [4:0]    shamt;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  aluout;
  logic          zero;
  logic          busy;

  alu_iter #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .srca       (srca),
    .srcb       (srcb),
    .alucontrol (alucontrol),
    .shamt      (shamt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .aluout     (aluout),
    .zero       (zero),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // Model-side expectation for the request in flight.
  bit          started  = 1'b0;
  bit          pending  = 1'b0;
  int          due      = 0;
  logic [31:0] exp_res  = '0;
  logic        exp_zero = 1'b0;
  logic [31:0] last_res = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Result and latency (cycles from accept to out_valid) of one request.
  function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] sh,
                                output logic [31:0] res, output int lat);
    lat = 1;
    res = '0;
    case (op)
      4'b0000: res = a + b;
      4'b1000: res = a - b;
      4'b0010: res = {31'b0, $signed(a) < $signed(b)};
      4'b0011: res = {31'b0, a < b};
      4'b0100: res = a ^ b;
      4'b0110: res = a | b;
      4'b0111: res = a & b;
      4'b0001: begin res = a << sh;           lat = int'(sh) + 1; end
      4'b0101: begin res = a >> sh;           lat = int'(sh) + 1; end
      4'b1101: begin res = $signed(a) >>> sh; lat = int'(sh) + 1; end
`ifdef ALU_ITER_MUL_EN
      4'b1001: begin res = a * b;             lat = W + 1; end
`endif
      default: res = '0;
    endcase
  endfunction

  // Per-cycle comparison against the model expectation.
  initial begin
    wait (started);
    forever begin
      @(negedge clk);
      #1;
      if (reset_n) begin
        if (!pending) begin
          check("idle in_ready",  in_ready,  1);
          check("idle busy",      busy,      0);
          check("idle out_valid", out_valid, 0);
          check("idle aluout",    aluout,    last_res);
        end else if (cyc < due) begin
          check("run in_ready",  in_ready,  0);
          check("run busy",      busy,      1);
          check("run out_valid", out_valid, 0);
          check("run aluout",    aluout,    last_res);
        end else begin
          check("done in_ready",  in_ready,  0);
          check("done busy",      busy,      1);
          check("done out_valid", out_valid, 1);
          check("done aluout",    aluout,    exp_res);
          check("done zero",      zero,      exp_zero);
        end
      end
    end
  end

  task automatic scramble_inputs(input bit force_valid);
    logic [31:0] r;
    r          = $urandom;
    in_valid   = force_valid ? 1'b1 : r[0];
    alucontrol = r[7:4];
    shamt      = r[12:8];
    srca       = $urandom;
    srcb       = $urandom;
  endtask

  // Issue one request, hold the result `hold` extra cycles in DONE, take it.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh,
                        input int hold, input bit force_valid);
    int  lat;
    bit  fin;
    logic [31:0] res;
    @(negedge clk);
    in_valid   = 1'b1;
    srca       = a;
    srcb       = b;
    alucontrol = op;
    shamt      = sh;
    @(posedge clk);
    #1;
    model(op, a, b, sh, res, lat);
    exp_res  = res;
    exp_zero = (a == b);
    due      = cyc + lat - 1;
    pending  = 1'b1;
    fin      = 1'b0;
    while (!fin) begin
      @(negedge clk);
      scramble_inputs(force_valid);
      fin = (cyc >= due + hold);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    pending   = 1'b0;
    last_res  = exp_res;
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] r;
    logic [31:0] edges [5];
    edges[0] = 32'h0000_0000;
    edges[1] = 32'h0000_0001;
    edges[2] = 32'hFFFF_FFFF;
    edges[3] = 32'h8000_0000;
    edges[4] = 32'h7FFF_FFFF;
    r = $urandom;
    if (r[2:0] < 3'd2) return edges[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] m_res;
    int          m_lat;
    logic [3:0]  ops [12];

    ops = '{4'b0000, 4'b1000, 4'b0010, 4'b0011, 4'b0100, 4'b0110,
            4'b0111, 4'b0001, 4'b0101, 4'b1101, 4'b1001, 4'b1111};

    // Hand-computed values that pin the model.
    model(4'b0000, 32'hFFFF_FFFF, 32'h1, 5'd0, m_res, m_lat);
    check("pin add wrap", m_res, 32'h0);
    check("pin add lat",  m_lat, 1);
    model(4'b0010, 32'h8000_0000, 32'h1, 5'd0, m_res, m_lat);
    check("pin slt", m_res, 32'h1);
    model(4'b0011, 32'h8000_0000, 32'h1, 5'd0, m_res, m_lat);
    check("pin sltu", m_res, 32'h0);
    model(4'b1101, 32'h8000_0000, 32'h0, 5'd4, m_res, m_lat);
    check("pin sra",     m_res, 32'hF800_0000);
    check("pin sra lat", m_lat, 5);
    model(4'b0001, 32'h0000_0003, 32'h0, 5'd31, m_res, m_lat);
    check("pin sll", m_res, 32'h8000_0000);
    model(4'b1001, 32'h0001_0001, 32'h0001_0001, 5'd0, m_res, m_lat);
`ifdef ALU_ITER_MUL_EN
    check("pin mul",     m_res, 32'h0002_0001);
    check("pin mul lat", m_lat, 33);
`else
    check("pin mul",     m_res, 32'h0);
    check("pin mul lat", m_lat, 1);
`endif

    // Reset.
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    srca       = '0;
    srcb       = '0;
    alucontrol = '0;
    shamt      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset aluout",    aluout,    0);
    check("reset out_valid", out_valid, 0);
    check("reset zero",      zero,      0);
    check("reset busy",      busy,      0);
    @(negedge clk);
    reset_n = 1'b1;
    started = 1'b1;
    #1;
    check("reset in_ready", in_ready, 1);

    // Directed corner cases.
    run_op(4'b0000, 32'hFFFF_FFFF, 32'h1,         5'd0, 0, 1'b0);
    run_op(4'b0010, 32'h8000_0000, 32'h1,         5'd0, 1, 1'b0);
    run_op(4'b0011, 32'h8000_0000, 32'h1,         5'd0, 0, 1'b0);
    run_op(4'b1000, 32'h5,         32'h5,         5'd0, 0, 1'b0);
    run_op(4'b1101, 32'h8000_0000, 32'h0,         5'd4, 0, 1'b0);
    run_op(4'b0100, 32'h1234_5678, 32'h0F0F_0F0F, 5'd0, 10, 1'b1);
    run_op(4'b1001, 32'h0001_0001, 32'h0001_0001, 5'd0, 0, 1'b0);
    run_op(4'b0101, 32'hDEAD_BEEF, 32'h0,         5'd0, 0, 1'b0);
    run_op(4'b0001, 32'h0000_0001, 32'h0,         5'd31, 0, 1'b0);
    run_op(4'b1111, 32'hFFFF_FFFF, 32'h1,         5'd0, 0, 1'b0);

    // Reset in the middle of a long shift.
    @(negedge clk);
    in_valid   = 1'b1;
    srca       = 32'hA5A5_A5A5;
    srcb       = 32'h0;
    alucontrol = 4'b0001;
    shamt      = 5'd20;
    @(posedge clk);
    #1;
    model(4'b0001, 32'hA5A5_A5A5, 32'h0, 5'd20, m_res, m_lat);
    exp_res  = m_res;
    exp_zero = 1'b0;
    due      = cyc + m_lat - 1;
    pending  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    pending  = 1'b0;
    last_res = '0;
    check("rst mid out_valid", out_valid, 0);
    check("rst mid aluout",    aluout,    0);
    check("rst mid busy",      busy,      0);
    check("rst mid zero",      zero,      0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst mid in_ready", in_ready, 1);

    // Randomized requests.
    for (int n = 0; n < 80; n++) begin
      r = $urandom;
      a = pick_operand();
      b = (r[3:0] == 4'd0) ? a : pick_operand();
      repeat (r[5:4]) @(negedge clk);
      run_op((r[8:6] == 3'd0) ? r[12:9] : ops[$urandom_range(0, 11)], a, b,
             (r[14:13] == 2'd0) ? 5'd0 : r[19:15],
             int'(r[21:20]), r[22]);
    end

    repeat (3) @(negedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
